// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic unit: operation codes and FSM states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_B2A = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

endpackage

// File: rtl/addsub_n.sv
// Parametrised ripple-carry adder/subtractor: sub inverts y and feeds the carry-in,
// so sum = x + ~y + 1 when sub=1 and cout is the no-borrow flag.
module addsub_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] y_eff;
  logic             c;

  assign y_eff = y ^ {WIDTH{sub}};

  always_comb begin
    sum = '0;
    c   = sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ y_eff[i] ^ c;
      c      = (x[i] & y_eff[i]) | (c & (x[i] ^ y_eff[i]));
    end
  end

  assign cout = c;

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-cycle add/sub/B-2A and a WIDTH-cycle shift-add
// multiplier, all sharing one addsub_n. Handshake: accept = start & ~busy at a rising
// edge; done pulses for one cycle with busy=0 and result/flags then hold until the next done.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carryOut,
  output logic               overflow,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   add_x;
  logic [WIDTH-1:0]   add_y;
  logic               add_sub;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] p_next;

  // In MUL the adder accumulates the multiplicand into the upper half of p;
  // otherwise it evaluates the latched add/sub operation.
  always_comb begin
    add_x   = a_r;
    add_y   = b_r;
    add_sub = 1'b0;
    if (state == S_MUL) begin
      add_x = p[2*WIDTH-1:WIDTH];
      add_y = p[0] ? a_r : '0;
    end else begin
      case (op_r)
        OP_SUB: add_sub = 1'b1;
        OP_B2A: begin
          add_x   = b_r;
          add_y   = {a_r[WIDTH-2:0], 1'b0};
          add_sub = 1'b1;
        end
        default: ;
      endcase
    end
  end

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Multiplier bits live in the low half of p and are consumed LSB first.
  assign p_next = {add_cout, add_sum, p[WIDTH-1:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      p        <= '0;
      count    <= '0;
      done     <= 1'b0;
      result   <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            count <= '0;
            p     <= {{WIDTH{1'b0}}, b};
            state <= (op == OP_MUL) ? S_MUL : S_CALC;
          end
        end
        S_CALC: begin
          result   <= {{WIDTH{1'b0}}, add_sum};
          carryOut <= add_cout;
          overflow <= 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        S_MUL: begin
          p     <= p_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            result   <= p_next;
            carryOut <= 1'b0;
            overflow <= |p_next[2*WIDTH-1:WIDTH];
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: the driver pushes expected {result, carry, overflow}
// into a queue at accept; an independent monitor pops and compares on every done pulse.
module tb_seq_arith_unit;
  import arith_pkg::*;

  localparam int W  = 16;
  localparam int EW = 2*W + 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op    = '0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           carry_out;
  logic           overflow;
  logic [1:0]     state_dbg;

  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [2*W-1:0] last_res = '0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carryOut  (carry_out),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && done) begin
      logic [EW-1:0] e;
      check("done_with_busy_low", 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",    64'(result),    64'(e[EW-1:2]));
        check("carry_out", 64'(carry_out), 64'(e[1]));
        check("overflow",  64'(overflow),  64'(e[0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with the unit idle (or in its done cycle).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [2*W-1:0] r, input logic c, input logic v,
                        input int lat, input bit poke);
    int n;
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(posedge clock);
    exp_q.push_back({r, c, v});
    #1;
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = W'($urandom_range(0, 65535));
    b     = W'($urandom_range(0, 65535));
    check("busy_after_accept", 64'(busy), 64'd1);
    check("result_held_at_accept", 64'(result), 64'(last_res));
    n = 0;
    while (n < 40) begin
      @(posedge clock);
      #1;
      n++;
      if (done) break;
      if (poke && n >= 2 && n <= 4) begin
        start = 1'b1;
        op    = OP_ADD;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
    last_res = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",     64'(busy),      64'd0);
    check("rst_done",     64'(done),      64'd0);
    check("rst_result",   64'(result),    64'd0);
    check("rst_carry",    64'(carry_out), 64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    check("rst_state",    64'(state_dbg), 64'(S_IDLE));

    // First start is presented together with reset release.
    reset = 1'b0;
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b0, 1,  1'b0);
    run_op(OP_SUB, 16'd5,    16'd7,    32'h0000_FFFE, 1'b0, 1'b0, 1,  1'b0);
    run_op(OP_SUB, 16'd7,    16'd5,    32'h0000_0002, 1'b1, 1'b0, 1,  1'b0);
    run_op(OP_B2A, 16'd3,    16'd10,   32'h0000_0004, 1'b1, 1'b0, 1,  1'b0);
    run_op(OP_B2A, 16'h8000, 16'h0000, 32'h0000_0000, 1'b1, 1'b0, 1,  1'b0);
    run_op(OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b1, 16, 1'b1);
    run_op(OP_MUL, 16'd3,    16'd5,    32'h0000_000F, 1'b0, 1'b0, 16, 1'b0);
    run_op(OP_ADD, 16'h1234, 16'h4321, 32'h0000_5555, 1'b0, 1'b0, 1,  1'b0);
    run_op(OP_MUL, 16'h0100, 16'h0100, 32'h0001_0000, 1'b0, 1'b1, 16, 1'b0);
    run_op(OP_MUL, 16'h0000, 16'hFFFF, 32'h0000_0000, 1'b0, 1'b0, 16, 1'b0);
    run_op(OP_B2A, 16'h0001, 16'h0001, 32'h0000_FFFF, 1'b0, 1'b0, 1,  1'b0);

    // Abort a multiply with reset after 5 cycles; no done may follow.
    start = 1'b1;
    op    = OP_MUL;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy",     64'(busy),      64'd0);
    check("abort_done",     64'(done),      64'd0);
    check("abort_result",   64'(result),    64'd0);
    check("abort_carry",    64'(carry_out), 64'd0);
    check("abort_overflow", 64'(overflow),  64'd0);
    check("abort_state",    64'(state_dbg), 64'(S_IDLE));
    last_res = '0;
    repeat (20) @(posedge clock);
    #1;
    check("abort_no_done_pending", 64'(exp_q.size()), 64'd0);

    run_op(OP_ADD, 16'd2, 16'd3, 32'h0000_0005, 1'b0, 1'b0, 1, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
